spi_regfile: RTL and testbench

- Control/status register file directly downstream of the SPI slave interface.
- Consumes the SPI-side address, write data and write-enable (`rf_addr`, `rf_din`, `wre`), all generated in the `sclk` domain.
- Returns read data on `rf_dout`.
- Brings the write strobe into the system clock domain and executes one register write per strobe.
- Holds RO ID, RW control, W1C status, IRQ enable and general-purpose config registers; exports them to the datapath and raises an interrupt.

---
 rtl/spi_regfile_pkg.sv | 24 ++
 rtl/spi_regfile_sync_ff.sv | 24 ++
 rtl/spi_regfile.sv | 200 ++++++++++++++++++++
 tb/tb_spi_regfile.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/spi_regfile_pkg.sv
// Shared constants for the SPI-facing control/status register file:
// address map, write-FSM state encoding and the CTRL lock bit position.
package spi_regfile_pkg;

    localparam logic [7:0] ADDR_ID      = 8'h00;
    localparam logic [7:0] ADDR_CTRL    = 8'h01;
    localparam logic [7:0] ADDR_STATUS  = 8'h02;
    localparam logic [7:0] ADDR_IRQEN   = 8'h03;
    localparam logic [7:0] ADDR_GP_BASE = 8'h04;

    localparam int CTRL_LOCK_BIT = 7;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WRITE    = 2'd1,
        ST_WAIT_LOW = 2'd2
    } wr_state_e;

    // True when addr falls inside the general-purpose window [base, gp_end).
    function automatic logic is_gp_addr(input logic [7:0] addr, input logic [7:0] gp_end);
        return (addr >= ADDR_GP_BASE) && (addr < gp_end);
    endfunction

endpackage

// File: rtl/spi_regfile_sync_ff.sv
// Single-bit level synchronizer with a configurable number of flops.
module sync_ff #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [DEPTH-1:0] sync_q;

    // Shift the asynchronous level through the synchronizer chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[DEPTH-2:0], d_i};
        end
    end

    assign q_o = sync_q[DEPTH-1];

endmodule

// File: rtl/spi_regfile.sv
// Control/status register file behind the SPI slave. The sclk-domain write
// enable is synchronized into clk and a small FSM executes exactly one write
// per wre level. Read data is a combinational mux sampled by the SPI side.
// Optional build macro SPI_REGFILE_LOCK_EN: CTRL[7] locks GP and IRQ_EN writes.
module spi_regfile
    import spi_regfile_pkg::*;
#(
    parameter logic [7:0] CHIP_ID     = 8'hA5,
    parameter int         NUM_GP      = 12,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            rf_addr,
    input  logic [7:0]            rf_din,
    input  logic                  wre,
    output logic [7:0]            rf_dout,
    input  logic [7:0]            evt_in,
    output logic [7:0]            ctrl_out,
    output logic [8*NUM_GP-1:0]   cfg_out,
    output logic                  irq,
    output logic                  wr_strobe,
    output logic [7:0]            wr_addr
);

    localparam logic [7:0] GP_END = ADDR_GP_BASE + 8'(NUM_GP);

    logic       wre_s;
    wr_state_e  state_q;
    logic       wr_strobe_q;
    logic [7:0] wr_addr_q;
    logic       irq_q;

    logic [7:0] ctrl_q,   ctrl_d;
    logic [7:0] status_q, status_d;
    logic [7:0] irqen_q,  irqen_d;
    logic [7:0] gp_q [NUM_GP];
    logic [7:0] gp_d [NUM_GP];

    logic       gp_hit_s;
    logic [7:0] gp_off_s;
    logic       locked_s;
    logic       wr_ok_s;
    logic       do_write_s;
    logic [7:0] w1c_s;
    logic [7:0] rd_data_s;

    sync_ff #(
        .DEPTH (SYNC_STAGES)
    ) u_wre_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (wre),
        .q_o   (wre_s)
    );

`ifdef SPI_REGFILE_LOCK_EN
    assign locked_s = ctrl_q[CTRL_LOCK_BIT];
`else
    assign locked_s = 1'b0;
`endif

    // Decode the target address and decide whether a write there is legal.
    always_comb begin
        gp_hit_s = is_gp_addr(rf_addr, GP_END);
        gp_off_s = rf_addr - ADDR_GP_BASE;
        wr_ok_s  = 1'b0;
        case (rf_addr)
            ADDR_ID:     wr_ok_s = 1'b0;
            ADDR_CTRL:   wr_ok_s = 1'b1;
            ADDR_STATUS: wr_ok_s = 1'b1;
            ADDR_IRQEN:  wr_ok_s = !locked_s;
            default:     wr_ok_s = gp_hit_s && !locked_s;
        endcase
    end

    assign do_write_s = (state_q == ST_WRITE) && wr_ok_s;

    // Write FSM: one write per synchronized wre level, with registered strobe/address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= 8'h00;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    wr_strobe_q <= 1'b0;
                    if (wre_s) begin
                        state_q <= ST_WRITE;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    wr_strobe_q <= wr_ok_s;
                    if (wr_ok_s) begin
                        wr_addr_q <= rf_addr;
                    end else begin
                        wr_addr_q <= wr_addr_q;
                    end
                    state_q <= ST_WAIT_LOW;
                end
                ST_WAIT_LOW: begin
                    wr_strobe_q <= 1'b0;
                    if (!wre_s) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_WAIT_LOW;
                    end
                end
                default: begin
                    wr_strobe_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    // Next-state for all registers; events set STATUS after the W1C so a set wins.
    always_comb begin
        ctrl_d  = ctrl_q;
        irqen_d = irqen_q;
        w1c_s   = 8'h00;
        for (int i = 0; i < NUM_GP; i++) begin
            gp_d[i] = gp_q[i];
        end
        if (do_write_s) begin
            case (rf_addr)
                ADDR_CTRL:   ctrl_d  = rf_din;
                ADDR_STATUS: w1c_s   = rf_din;
                ADDR_IRQEN:  irqen_d = rf_din;
                default: begin
                    for (int i = 0; i < NUM_GP; i++) begin
                        if (gp_hit_s && (gp_off_s == 8'(i))) begin
                            gp_d[i] = rf_din;
                        end else begin
                            gp_d[i] = gp_q[i];
                        end
                    end
                end
            endcase
        end else begin
            w1c_s = 8'h00;
        end
        status_d = (status_q & ~w1c_s) | evt_in;
    end

    // Register storage and the registered interrupt output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q   <= 8'h00;
            status_q <= 8'h00;
            irqen_q  <= 8'h00;
            irq_q    <= 1'b0;
            for (int i = 0; i < NUM_GP; i++) begin
                gp_q[i] <= 8'h00;
            end
        end else begin
            ctrl_q   <= ctrl_d;
            status_q <= status_d;
            irqen_q  <= irqen_d;
            irq_q    <= |(status_q & irqen_q);
            for (int i = 0; i < NUM_GP; i++) begin
                gp_q[i] <= gp_d[i];
            end
        end
    end

    // Combinational read mux on the SPI-side address; unmapped addresses read zero.
    always_comb begin
        rd_data_s = 8'h00;
        case (rf_addr)
            ADDR_ID:     rd_data_s = CHIP_ID;
            ADDR_CTRL:   rd_data_s = ctrl_q;
            ADDR_STATUS: rd_data_s = status_q;
            ADDR_IRQEN:  rd_data_s = irqen_q;
            default: begin
                for (int i = 0; i < NUM_GP; i++) begin
                    if (gp_hit_s && (gp_off_s == 8'(i))) begin
                        rd_data_s = gp_q[i];
                    end else begin
                        rd_data_s = rd_data_s;
                    end
                end
            end
        endcase
    end

    for (genvar g = 0; g < NUM_GP; g++) begin : g_cfg
        assign cfg_out[8*g +: 8] = gp_q[g];
    end

    assign rf_dout   = rd_data_s;
    assign ctrl_out  = ctrl_q;
    assign irq       = irq_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;

endmodule

// File: tb/tb_spi_regfile.sv
// Directed self-checking bench for spi_regfile (default parameters).
module tb_spi_regfile;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rf_addr;
    logic [7:0]  rf_din;
    logic        wre;
    logic [7:0]  rf_dout;
    logic [7:0]  evt_in;
    logic [7:0]  ctrl_out;
    logic [95:0] cfg_out;
    logic        irq;
    logic        wr_strobe;
    logic [7:0]  wr_addr;

    int total = 0;
    int bad   = 0;
    int strobe_cnt = 0;
    int snap;

    spi_regfile dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rf_addr   (rf_addr),
        .rf_din    (rf_din),
        .wre       (wre),
        .rf_dout   (rf_dout),
        .evt_in    (evt_in),
        .ctrl_out  (ctrl_out),
        .cfg_out   (cfg_out),
        .irq       (irq),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count strobe pulses, sampled away from the active edge.
    always @(negedge clk) begin
        if (wr_strobe === 1'b1) strobe_cnt <= strobe_cnt + 1;
    end

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_rd(input string tag, input logic [7:0] a, input logic [7:0] exp);
        rf_addr = a;
        #1;
        check(tag, {88'h0, rf_dout}, {88'h0, exp});
    endtask

    // One SPI byte write: wre high for hi clk cycles, then low for lo cycles.
    task automatic spi_write(input logic [7:0] a, input logic [7:0] d, input int hi, input int lo);
        @(negedge clk);
        rf_addr = a;
        rf_din  = d;
        wre     = 1'b1;
        repeat (hi) @(negedge clk);
        wre = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; rf_addr = 8'h00; rf_din = 8'h00; wre = 1'b0; evt_in = 8'h00;
        repeat (2) @(negedge clk);
        check_rd("id_in_reset", 8'h00, 8'hA5);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state
        check_rd("rd_id",   8'h00, 8'hA5);
        check_rd("rd_ctrl", 8'h01, 8'h00);
        check_rd("rd_gp05", 8'h05, 8'h00);
        check_rd("rd_ff",   8'hFF, 8'h00);
        check("irq_rst",    {95'h0, irq}, 96'h0);
        check("cfg_rst",    cfg_out, 96'h0);
        check("wraddr_rst", {88'h0, wr_addr}, 96'h0);

        // Long wre level writes once
        snap = strobe_cnt;
        spi_write(8'h05, 8'h3C, 10, 4);
        check("long_one_strobe", 96'(strobe_cnt - snap), 96'd1);
        check("long_cfg", {88'h0, cfg_out[15:8]}, 96'h3C);
        check("long_wraddr", {88'h0, wr_addr}, 96'h05);
        check_rd("long_rd", 8'h05, 8'h3C);

        // Burst at sclk period of 6 clk
        snap = strobe_cnt;
        spi_write(8'h04, 8'h11, 3, 3);
        spi_write(8'h05, 8'h22, 3, 3);
        spi_write(8'h06, 8'h33, 3, 3);
        spi_write(8'h07, 8'h44, 3, 3);
        repeat (3) @(negedge clk);
        check("burst_strobes", 96'(strobe_cnt - snap), 96'd4);
        check("burst_cfg", {64'h0, cfg_out[31:0]}, 96'h44332211);
        check("burst_wraddr", {88'h0, wr_addr}, 96'h07);

        // Last GP register and first address past the GP window
        snap = strobe_cnt;
        spi_write(8'h0F, 8'h99, 4, 4);
        spi_write(8'h10, 8'h77, 4, 4);
        check("gp_edge_strobes", 96'(strobe_cnt - snap), 96'd1);
        check("gp_last_cfg", {88'h0, cfg_out[95:88]}, 96'h99);
        check_rd("gp_past_rd", 8'h10, 8'h00);

        // CTRL write
        spi_write(8'h01, 8'h5A, 4, 4);
        check("ctrl_out", {88'h0, ctrl_out}, 96'h5A);

        // Events, IRQ enable and W1C
        spi_write(8'h03, 8'h01, 4, 4);
        @(negedge clk);
        evt_in = 8'h81;
        @(negedge clk);
        evt_in = 8'h00;
        @(negedge clk);
        check("irq_set", {95'h0, irq}, 96'h1);
        check_rd("status_81", 8'h02, 8'h81);
        evt_in = 8'h01;
        spi_write(8'h02, 8'h01, 4, 1);
        evt_in = 8'h00;
        check_rd("status_set_wins", 8'h02, 8'h81);
        spi_write(8'h02, 8'h01, 4, 4);
        check_rd("status_w1c", 8'h02, 8'h80);
        check("irq_clear", {95'h0, irq}, 96'h0);

        // Ignored writes
        snap = strobe_cnt;
        spi_write(8'h00, 8'h00, 4, 4);
        spi_write(8'h20, 8'h55, 4, 4);
        check("ign_no_strobe", 96'(strobe_cnt - snap), 96'd0);
        check_rd("ign_id", 8'h00, 8'hA5);
        check_rd("ign_20", 8'h20, 8'h00);
        check("ign_wraddr", {88'h0, wr_addr}, 96'h02);

`ifdef SPI_REGFILE_LOCK_EN
        spi_write(8'h01, 8'h80, 4, 4);
        snap = strobe_cnt;
        spi_write(8'h08, 8'hFF, 4, 4);
        spi_write(8'h03, 8'h00, 4, 4);
        check("lock_no_strobe", 96'(strobe_cnt - snap), 96'd0);
        check("lock_gp", {88'h0, cfg_out[39:32]}, 96'h00);
        check_rd("lock_irqen", 8'h03, 8'h01);
        spi_write(8'h01, 8'h00, 4, 4);
        spi_write(8'h08, 8'hFF, 4, 4);
        check("unlock_gp", {88'h0, cfg_out[39:32]}, 96'hFF);
`else
        spi_write(8'h01, 8'h80, 4, 4);
        snap = strobe_cnt;
        spi_write(8'h08, 8'hFF, 4, 4);
        check("nolock_strobe", 96'(strobe_cnt - snap), 96'd1);
        check("nolock_gp", {88'h0, cfg_out[39:32]}, 96'hFF);
        check("nolock_ctrl", {88'h0, ctrl_out}, 96'h80);
`endif

        // Reset asserted while the FSM is in WRITE
        snap = strobe_cnt;
        @(negedge clk);
        rf_addr = 8'h06;
        rf_din  = 8'hEE;
        wre     = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        wre   = 1'b0;
        #1;
        check("rst_cfg", cfg_out, 96'h0);
        check("rst_ctrl", {88'h0, ctrl_out}, 96'h0);
        check("rst_irq", {95'h0, irq}, 96'h0);
        check("rst_wraddr", {88'h0, wr_addr}, 96'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("rst_no_strobe", 96'(strobe_cnt - snap), 96'd0);
        check("rst_gp06", {88'h0, cfg_out[23:16]}, 96'h00);
        check_rd("rst_status", 8'h02, 8'h00);
        check_rd("rst_irqen", 8'h03, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
